// File: rtl/jpegls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpegls_pkg
//  Description : Shared constants and types for the JPEG-LS bit unpacker.
//                Holds the marker prefix, the EOI code, the stuffed-byte
//                payload width, default geometry of the peek window and
//                bit buffer, and the derivation of the counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpegls_pkg;

    // Byte that introduces either a stuffed byte or a marker.
    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    // End-of-image marker code.
    localparam logic [7:0] EOI           = 8'hD9;
    // A byte following 0xFF with MSB clear carries only this many data bits.
    localparam int         STUFF_BITS    = 7;

    localparam int DEFAULT_WINDOW_WIDTH = 32;
    localparam int DEFAULT_BUFFER_WIDTH = 64;

    // Counters must be able to hold every value from 0 to the buffer depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_BUFFER_WIDTH);

    // State of the stuffing filter: whether the previous byte was 0xFF.
    typedef enum logic [0:0] {
        ST_NORMAL     = 1'b0,
        ST_FF_PENDING = 1'b1
    } stuff_state_t;

endpackage : jpegls_pkg
`default_nettype wire

// File: rtl/jpegls_stuff_filter.sv
`default_nettype none
// ============================================================================
//  Module      : jpegls_stuff_filter
//  Description : Removes JPEG-LS bit stuffing from the incoming byte stream
//                and detects markers. For every accepted byte it reports the
//                bits to append to the bit buffer (MSB-aligned in a 16-bit
//                field, unused low bits zero) and their count.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                byteIn/byteValid - accepted byte and its strobe
//                appendBits       - bits to append, MSB = oldest
//                appendLen        - number of valid appendBits (0/8/15)
//                markerHit        - marker recognised on this byte
//                markerCode       - second byte of that marker
//  Revision    : 1.0 - initial release
// ============================================================================
module jpegls_stuff_filter
    import jpegls_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic [15:0] appendBits,
    output logic [3:0]  appendLen,
    output logic        markerHit,
    output logic [7:0]  markerCode
);

    localparam logic [3:0] LEN_BYTE    = 4'd8;
    localparam logic [3:0] LEN_STUFFED = 4'(8 + STUFF_BITS);

    stuff_state_t state;
    stuff_state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        appendBits = 16'h0000;
        appendLen  = 4'd0;
        markerHit  = 1'b0;
        markerCode = 8'h00;

        if (byteValid) begin
            case (state)
                ST_NORMAL: begin
                    if (byteIn == MARKER_PREFIX) begin
                        // Hold the 0xFF back until the next byte tells us
                        // whether it is data or a marker prefix.
                        state_next = ST_FF_PENDING;
                    end else begin
                        appendBits = {byteIn, 8'h00};
                        appendLen  = LEN_BYTE;
                    end
                end
                ST_FF_PENDING: begin
                    state_next = ST_NORMAL;
                    if (!byteIn[7]) begin
                        // Stuffed byte: the deferred 0xFF is data, followed
                        // by the 7 payload bits of this byte.
                        appendBits = {MARKER_PREFIX, byteIn[STUFF_BITS-1:0], 1'b0};
                        appendLen  = LEN_STUFFED;
                    end else begin
                        // Marker: the 0xFF prefix is dropped.
                        markerHit  = 1'b1;
                        markerCode = byteIn;
                    end
                end
                default: state_next = ST_NORMAL;
            endcase
        end
    end

endmodule : jpegls_stuff_filter
`default_nettype wire

// File: rtl/jpegls_bit_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : jpegls_bit_unpacker
//  Description : Decoder-side front end for the JPEG-LS entropy-coded
//                segment. Accepts bytes, strips bit stuffing, stalls on
//                markers and presents an MSB-first peek window from which
//                the decoder consumes a variable number of bits per cycle.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                byteIn/byteValid/byteReady - byte intake handshake
//                window/windowBits          - peek window and its fill
//                consume/consumeValid       - bits to discard from window top
//                consumeError               - pulse: over-consume rejected
//                markerDetected/markerCode  - marker stall and its code
//                markerClear                - release a marker stall
//  Revision    : 1.0 - initial release
// ============================================================================
module jpegls_bit_unpacker
    import jpegls_pkg::*;
#(
    parameter int WINDOW_WIDTH = DEFAULT_WINDOW_WIDTH,
    parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
    parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              byteIn,
    input  logic                    byteValid,
    output logic                    byteReady,
    output logic [WINDOW_WIDTH-1:0] window,
    output logic [COUNT_WIDTH-1:0]  windowBits,
    input  logic [COUNT_WIDTH-1:0]  consume,
    input  logic                    consumeValid,
    output logic                    consumeError,
    output logic                    markerDetected,
    output logic [7:0]              markerCode,
    input  logic                    markerClear
);

    // Intake stops once fewer than 16 free bits remain, so the widest append
    // (15 bits) always fits.
    localparam logic [COUNT_WIDTH-1:0] READY_LIMIT = COUNT_WIDTH'(BUFFER_WIDTH - 16);
    localparam logic [COUNT_WIDTH-1:0] WINDOW_MAX  = COUNT_WIDTH'(WINDOW_WIDTH);

    // Buffer is MSB-aligned: bit BUFFER_WIDTH-1 is the oldest unconsumed bit
    // and every bit below the fill level is held at zero.
    logic [BUFFER_WIDTH-1:0] buffer;
    logic [BUFFER_WIDTH-1:0] buffer_next;
    logic [BUFFER_WIDTH-1:0] append_field;
    logic [COUNT_WIDTH-1:0]  fill;
    logic [COUNT_WIDTH-1:0]  fill_next;
    logic [COUNT_WIDTH-1:0]  consume_amt;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [COUNT_WIDTH-1:0]  append_len_ext;

    logic                    transfer;
    logic                    consume_ok;
    logic                    consume_bad;

    logic [15:0]             append_bits;
    logic [3:0]              append_len;
    logic                    marker_hit;
    logic [7:0]              hit_code;

    assign byteReady  = (fill <= READY_LIMIT) && !markerDetected;
    assign transfer   = byteValid && byteReady;

    assign windowBits = (fill > WINDOW_MAX) ? WINDOW_MAX : fill;
    assign window     = buffer[BUFFER_WIDTH-1 -: WINDOW_WIDTH];

    assign consume_ok  = consumeValid && (consume <= windowBits);
    assign consume_bad = consumeValid && (consume >  windowBits);
    assign consume_amt = consume_ok ? consume : '0;
    assign remaining   = fill - consume_amt;

    jpegls_stuff_filter u_stuff_filter (
        .clk        (clk),
        .reset      (reset),
        .byteIn     (byteIn),
        .byteValid  (transfer),
        .appendBits (append_bits),
        .appendLen  (append_len),
        .markerHit  (marker_hit),
        .markerCode (hit_code)
    );

    assign append_len_ext = COUNT_WIDTH'(append_len);

    // Appended bits are dropped in right after the last bit that survives
    // this cycle's consume; low bits of append_bits are zero so the
    // below-fill region stays clear.
    always_comb begin
        append_field = {append_bits, {(BUFFER_WIDTH-16){1'b0}}};
        buffer_next  = (buffer << consume_amt) | (append_field >> remaining);
        fill_next    = remaining + append_len_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer         <= '0;
            fill           <= '0;
            consumeError   <= 1'b0;
            markerDetected <= 1'b0;
            markerCode     <= 8'h00;
        end else begin
            buffer       <= buffer_next;
            fill         <= fill_next;
            consumeError <= consume_bad;
            // A new detection takes priority over a simultaneous clear.
            if (marker_hit) begin
                markerDetected <= 1'b1;
                markerCode     <= hit_code;
            end else if (markerClear) begin
                markerDetected <= 1'b0;
            end
        end
    end

endmodule : jpegls_bit_unpacker
`default_nettype wire
